// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready handshake.
// Define CLA_ADD_OVF_EN to add the registered signed-overflow output out_ovf.

// 4-bit lookahead cell: bit carries from per-bit P/G, plus group propagate/generate.
module cla_4 (
  input  logic [3:0] p_i,
  input  logic [3:0] g_i,
  input  logic       c_i,
  output logic [4:1] c_o,
  output logic       pm_o,
  output logic       gm_o
);

  assign pm_o = &p_i;
  assign gm_o = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
              | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);

  assign c_o[1] = g_i[0] | (p_i[0] & c_i);
  assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
  assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                | (p_i[2] & p_i[1] & p_i[0] & c_i);
  assign c_o[4] = gm_o | (pm_o & c_i);

endmodule

module cla_add_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CLA_ADD_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned NG   = WIDTH / 4;
  localparam int unsigned MAXG = 4;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_p_q, s1_p_d;
  logic [WIDTH-1:0] s1_g_q, s1_g_d;
  logic             s1_cin_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             adv1, adv2;

  // Advance conditions: in_ready is purely combinational, no skid buffer.
  assign adv2     = !out_valid_q | out_ready;
  assign adv1     = !s1_valid_q | adv2;
  assign in_ready = adv1;

  assign s1_p_d = in_a ^ in_b;
  assign s1_g_d = in_a & in_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_cin_q   <= 1'b0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      s1_p_q     <= s1_p_d;
      s1_g_q     <= s1_g_d;
      s1_cin_q   <= in_cin;
    end
  end

  logic [MAXG-1:0] grp_pm, grp_gm;
  logic [4:0]      blk_c;
  logic            blk_pm, blk_gm;
  logic [WIDTH:0]  carry;

  // Group cells; unused group slots feed P=0/G=0 into the block cell.
  for (genvar i = 0; i < MAXG; i++) begin : g_grp
    if (i < NG) begin : g_used
      logic [4:1] gc;
      logic       unused_gc4;
      cla_4 u_grp (
        .p_i  (s1_p_q[4*i +: 4]),
        .g_i  (s1_g_q[4*i +: 4]),
        .c_i  (blk_c[i]),
        .c_o  (gc),
        .pm_o (grp_pm[i]),
        .gm_o (grp_gm[i])
      );
      assign carry[4*i]         = blk_c[i];
      assign carry[4*i+1 +: 3]  = gc[3:1];
      assign unused_gc4         = gc[4];
    end else begin : g_pad
      assign grp_pm[i] = 1'b0;
      assign grp_gm[i] = 1'b0;
    end
  end

  cla_4 u_blk (
    .p_i  (grp_pm),
    .g_i  (grp_gm),
    .c_i  (s1_cin_q),
    .c_o  (blk_c[4:1]),
    .pm_o (blk_pm),
    .gm_o (blk_gm)
  );
  assign blk_c[0]     = s1_cin_q;
  assign carry[WIDTH] = blk_c[NG];

  logic unused_blk;
  assign unused_blk = ^{blk_pm, blk_gm, blk_c};

  assign out_sum_d  = s1_p_q ^ carry[WIDTH-1:0];
  assign out_cout_d = carry[WIDTH];

  // Output stage holds its data while stalled and across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sum_q  <= out_sum_d;
        out_cout_q <= out_cout_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;

`ifdef CLA_ADD_OVF_EN
  logic out_ovf_q, out_ovf_d;

  assign out_ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_ovf_q <= 1'b0;
    end else if (adv2 && s1_valid_q) begin
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_ovf = out_ovf_q;
`endif

endmodule

// File: tb/tb_cla_add_pipe.sv
// Self-checking bench for cla_add_pipe: WIDTH=16 and WIDTH=8 instances,
// arithmetic scoreboard plus hand-computed directed expectations.
module tb_cla_add_pipe;

  logic clk = 1'b0;
  logic rst_n;

  logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, out_cout16;
  logic [15:0] a16, b16, out_sum16;
  logic        in_valid8, in_ready8, cin8, out_valid8, out_ready8, out_cout8;
  logic [7:0]  a8, b8, out_sum8;
`ifdef CLA_ADD_OVF_EN
  logic        out_ovf16, out_ovf8;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] q16[$];
  logic [17:0] q8[$];

  always #5 clk = ~clk;

  cla_add_pipe #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(a16), .in_b(b16), .in_cin(cin16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .out_sum(out_sum16), .out_cout(out_cout16)
`ifdef CLA_ADD_OVF_EN
    , .out_ovf(out_ovf16)
`endif
  );

  cla_add_pipe #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(a8), .in_b(b8), .in_cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_sum(out_sum8), .out_cout(out_cout8)
`ifdef CLA_ADD_OVF_EN
    , .out_ovf(out_ovf8)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: {ovf, cout, sum} from integer arithmetic on a w-bit add.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    int m, ua, ub, full, sa, sb, t;
    logic ovf, cout;
    m    = 1 << w;
    ua   = int'(a) % m;
    ub   = int'(b) % m;
    full = ua + ub + int'(cin);
    sa   = (ua >= m / 2) ? ua - m : ua;
    sb   = (ub >= m / 2) ? ub - m : ub;
    t    = sa + sb + int'(cin);
    ovf  = (t >= m / 2) || (t < -(m / 2));
    cout = (full >= m);
    return {ovf, cout, 16'(full % m)};
  endfunction

  always @(negedge rst_n) begin
    q16.delete();
    q8.delete();
  end

  // Scoreboard bookkeeping on the active edge (pre-edge handshake values).
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (in_valid16 && in_ready16) q16.push_back(model(16, a16, b16, cin16));
      if (out_valid16 && out_ready16 && q16.size() > 0) void'(q16.pop_front());
      if (in_valid8 && in_ready8) q8.push_back(model(8, {8'h00, a8}, {8'h00, b8}, cin8));
      if (out_valid8 && out_ready8 && q8.size() > 0) void'(q8.pop_front());
    end
  end

  // Compare every cycle an output is valid.
  always @(negedge clk) begin : cmp
    logic [17:0] e;
    if (rst_n === 1'b1 && out_valid16) begin
      if (q16.size() == 0) begin
        n_checks++;
        $display("FAIL sb16_spurious: out_valid with sum %0h, expected no result", out_sum16);
      end else begin
        e = q16[0];
        check("sb16_sum", 32'(out_sum16), 32'(e[15:0]));
        check("sb16_cout", 32'(out_cout16), 32'(e[16]));
`ifdef CLA_ADD_OVF_EN
        check("sb16_ovf", 32'(out_ovf16), 32'(e[17]));
`endif
      end
    end
    if (rst_n === 1'b1 && out_valid8) begin
      if (q8.size() == 0) begin
        n_checks++;
        $display("FAIL sb8_spurious: out_valid with sum %0h, expected no result", out_sum8);
      end else begin
        e = q8[0];
        check("sb8_sum", 32'(out_sum8), 32'(e[7:0]));
        check("sb8_cout", 32'(out_cout8), 32'(e[16]));
`ifdef CLA_ADD_OVF_EN
        check("sb8_ovf", 32'(out_ovf8), 32'(e[17]));
`endif
      end
    end
  end

  // Present one operand set and wait (bounded) until it is accepted.
  task automatic send(input bit sel8, input logic [15:0] a, input logic [15:0] b, input logic cin);
    bit acc = 1'b0;
    if (sel8) begin
      in_valid8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; cin8 = cin;
    end else begin
      in_valid16 = 1'b1; a16 = a; b16 = b; cin16 = cin;
    end
    for (int n = 0; n < 64 && !acc; n++) begin
      #1;
      acc = sel8 ? in_ready8 : in_ready16;
      @(negedge clk);
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0, expected acceptance");
    end
    if (sel8) in_valid8 = 1'b0;
    else in_valid16 = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int acc8, acc16;
    bit take8, take16;

    rst_n = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; out_ready16 = 1'b1;
    in_valid8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; out_ready8  = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready16), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_valid", 32'(out_valid16), 32'd0);
    check("idle_sum", 32'(out_sum16), 32'h0000);
    check("idle_cout", 32'(out_cout16), 32'd0);
    check("idle_in_ready", 32'(in_ready16), 32'd1);

    // Single op, two-edge latency, one-cycle valid pulse.
    send(1'b0, 16'h1234, 16'h4321, 1'b0);
    check("single_early_valid", 32'(out_valid16), 32'd0);
    @(negedge clk);
    check("single_valid", 32'(out_valid16), 32'd1);
    check("single_sum", 32'(out_sum16), 32'h5555);
    check("single_cout", 32'(out_cout16), 32'd0);
    @(negedge clk);
    check("single_valid_drop", 32'(out_valid16), 32'd0);

    // Full carry ripple and signed overflow.
    send(1'b0, 16'hFFFF, 16'h0000, 1'b1);
    @(negedge clk);
    check("ripple_sum", 32'(out_sum16), 32'h0000);
    check("ripple_cout", 32'(out_cout16), 32'd1);
`ifdef CLA_ADD_OVF_EN
    check("ripple_ovf", 32'(out_ovf16), 32'd0);
`endif
    send(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    check("ovf_sum", 32'(out_sum16), 32'h8000);
    check("ovf_cout", 32'(out_cout16), 32'd0);
`ifdef CLA_ADD_OVF_EN
    check("ovf_ovf", 32'(out_ovf16), 32'd1);
`endif
    @(negedge clk);

    // Backpressure: three ops with out_ready low for three cycles.
    out_ready16 = 1'b0;
    in_valid16 = 1'b1; a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0;
    @(negedge clk);
    a16 = 16'h0002; b16 = 16'h0002;
    @(negedge clk);
    check("bp_in_ready_full", 32'(in_ready16), 32'd0);
    check("bp_valid", 32'(out_valid16), 32'd1);
    check("bp_sum_first", 32'(out_sum16), 32'h0002);
    a16 = 16'h0003; b16 = 16'h0003;
    @(negedge clk);
    check("bp_sum_hold", 32'(out_sum16), 32'h0002);
    check("bp_in_ready_hold", 32'(in_ready16), 32'd0);
    out_ready16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0;
    check("bp_sum_second", 32'(out_sum16), 32'h0004);
    @(negedge clk);
    check("bp_sum_third", 32'(out_sum16), 32'h0006);
    @(negedge clk);
    check("bp_drained", 32'(out_valid16), 32'd0);

    // Reset with both stages holding data.
    out_ready16 = 1'b0;
    send(1'b0, 16'h0011, 16'h0022, 1'b0);
    send(1'b0, 16'h0033, 16'h0044, 1'b0);
    check("mid_full_valid", 32'(out_valid16), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid16), 32'd0);
    check("mid_rst_sum", 32'(out_sum16), 32'h0000);
    check("mid_rst_in_ready", 32'(in_ready16), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready16 = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'(out_valid16), 32'd0);
    send(1'b0, 16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid16), 32'd1);
    check("post_rst_sum", 32'(out_sum16), 32'h0100);
    @(negedge clk);

    // WIDTH=8 wrap-around.
    send(1'b1, 16'h00F0, 16'h0010, 1'b0);
    @(negedge clk);
    check("w8_valid", 32'(out_valid8), 32'd1);
    check("w8_sum", 32'(out_sum8), 32'h00);
    check("w8_cout", 32'(out_cout8), 32'd1);
    @(negedge clk);

    // Back-to-back random stream on both instances with random backpressure.
    acc8 = 0; acc16 = 0;
    in_valid8  = 1'b1; a8  = 8'($urandom);  b8  = 8'($urandom);  cin8  = 1'($urandom);
    in_valid16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    for (int cyc = 0; cyc < 40000 && (acc8 < 10000 || acc16 < 10000); cyc++) begin
      out_ready8  = ($urandom_range(0, 3) != 0);
      out_ready16 = ($urandom_range(0, 3) != 0);
      #1;
      take8  = in_valid8 && in_ready8;
      take16 = in_valid16 && in_ready16;
      @(negedge clk);
      if (take8) begin
        acc8++;
        if (acc8 < 10000) begin
          a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        end else in_valid8 = 1'b0;
      end
      if (take16) begin
        acc16++;
        if (acc16 < 10000) begin
          a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
        end else in_valid16 = 1'b0;
      end
    end
    in_valid8 = 1'b0; in_valid16 = 1'b0;
    out_ready8 = 1'b1; out_ready16 = 1'b1;
    repeat (4) @(negedge clk);
    check("rand8_accepted", 32'(acc8), 32'd10000);
    check("rand16_accepted", 32'(acc16), 32'd10000);
    check("rand8_none_lost", 32'(q8.size()), 32'd0);
    check("rand16_none_lost", 32'(q16.size()), 32'd0);
    check("rand8_idle", 32'(out_valid8), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
